// File: rtl/row_col_dec_pkg.sv
// Shared DCO cap-bank constants and helpers.
// Reset patterns here are shared with the selector encoder.
package row_col_dec_pkg;

    localparam int ROW_W_DFLT = 4;
    localparam int MAX_W      = 256;

    function automatic int size_of(input int row_w);
        return 1 << row_w;
    endfunction

    function automatic int word_w_of(input int row_w);
        return 2 * row_w;
    endfunction

    // Half-on bank: lower SIZE/2 rows full, partial row at SIZE/2.
    function automatic logic [MAX_W-1:0] rall_rst(input int size);
        return (MAX_W'(1) << (size / 2)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] row_rst(input int size);
        return MAX_W'(1) << (size / 2);
    endfunction

    function automatic logic [MAX_W-1:0] col_rst();
        return '0;
    endfunction

    function automatic logic [MAX_W-1:0] word_rst(input int word_w);
        return MAX_W'(1) << (word_w - 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/row_col_dec_therm_chk.sv
// Thermometer-code check and ones count for one selector vector.
// MSB_FIRST=1 expects the ones to fill downward from bit W-1.
module therm_chk
    import row_col_dec_pkg::*;
#(
    parameter int W         = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [W-1:0]           vec,
    output logic                   is_therm,
    output logic [$clog2(W+1)-1:0] count
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0] lsb_v;

    always_comb begin
        lsb_v = vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < W; i++) begin
                lsb_v[i] = vec[W-1-i];
            end
        end
    end

    // 2^k-1 patterns are the only ones with no overlap against v+1.
    assign is_therm = ((lsb_v + W'(1)) & lsb_v) == '0;
    assign count    = CW'(popcount(MAX_W'(vec)));

endmodule

// File: rtl/row_col_dec.sv
// DCO cap-bank selector decoder: r_all/row/col back to the tuning word.
// Define ROW_COL_DEC_CHECK_EN to build the selector legality checks.
module row_col_dec
    import row_col_dec_pkg::*;
#(
    parameter int ROW_W     = ROW_W_DFLT,
    parameter int SIZE      = size_of(ROW_W),
    parameter int WORD_W    = word_w_of(ROW_W),
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [SIZE-1:0]      r_all,
    input  logic [SIZE-1:0]      row,
    input  logic [SIZE-1:0]      col,
    input  logic                 err_clr,
    output logic [WORD_W-1:0]    word,
    output logic                 word_vld,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [SIZE-1:0]   s_rall_q;
    logic [SIZE-1:0]   s_row_q;
    logic [SIZE-1:0]   s_col_q;
    logic              s_vld_q;
    logic [ROW_W-1:0]  r;
    logic [ROW_W-1:0]  c;
    logic              legal;
    logic              word_vld_d;
    logic [WORD_W-1:0] word_d;
    logic [WORD_W-1:0] word_q;
    logic              word_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rall_q <= SIZE'(rall_rst(SIZE));
            s_row_q  <= SIZE'(row_rst(SIZE));
            s_col_q  <= SIZE'(col_rst());
            s_vld_q  <= 1'b0;
        end else begin
            s_vld_q <= en;
            if (en) begin
                s_rall_q <= r_all;
                s_row_q  <= row;
                s_col_q  <= col;
            end
        end
    end

`ifdef ROW_COL_DEC_CHECK_EN
    logic [ROW_W:0] r_cnt;
    logic [ROW_W:0] c_cnt_lsb;
    logic [ROW_W:0] c_cnt_msb;
    logic [ROW_W:0] c_cnt;
    logic           rall_th;
    logic           col_th_lsb;
    logic           col_th_msb;
    logic           col_th;

    therm_chk #(.W(SIZE), .MSB_FIRST(1'b0)) u_rall_chk (
        .vec      (s_rall_q),
        .is_therm (rall_th),
        .count    (r_cnt)
    );

    therm_chk #(.W(SIZE), .MSB_FIRST(1'b0)) u_col_lsb_chk (
        .vec      (s_col_q),
        .is_therm (col_th_lsb),
        .count    (c_cnt_lsb)
    );

    therm_chk #(.W(SIZE), .MSB_FIRST(1'b1)) u_col_msb_chk (
        .vec      (s_col_q),
        .is_therm (col_th_msb),
        .count    (c_cnt_msb)
    );

    // Serpentine: odd rows fill their columns from the top.
    assign r      = r_cnt[ROW_W-1:0];
    assign col_th = r[0] ? col_th_msb : col_th_lsb;
    assign c_cnt  = r[0] ? c_cnt_msb : c_cnt_lsb;
    assign c      = c_cnt[ROW_W-1:0];

    assign legal = rall_th && !r_cnt[ROW_W]
                && $onehot(s_row_q)
                && (s_row_q == (SIZE'(1) << r))
                && col_th && !c_cnt[ROW_W];

    logic                 err_d;
    logic                 err_q;
    logic                 err_sticky_d;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_comb begin
        err_d        = s_vld_q && !legal;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = err_d ? ERR_CNT_W'(1) : '0;
        end else if (err_d) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
`else
    logic unused_in;

    assign r     = ROW_W'(popcount(MAX_W'(s_rall_q)));
    assign c     = ROW_W'(popcount(MAX_W'(s_col_q)));
    assign legal = 1'b1;

    assign unused_in  = err_clr ^ (|s_row_q);
    assign err        = 1'b0;
    assign err_sticky = 1'b0;
    assign err_cnt    = '0;
`endif

    always_comb begin
        word_vld_d = s_vld_q && legal;
        word_d     = word_q;
        if (word_vld_d) begin
            word_d = {r, c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= WORD_W'(word_rst(WORD_W));
            word_vld_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign word     = word_q;
    assign word_vld = word_vld_q;

endmodule

// File: tb/tb_row_col_dec.sv
// Scoreboard bench for row_col_dec against a rule-level reference.
// Expectations follow ROW_COL_DEC_CHECK_EN the same way as the DUT.
module tb_row_col_dec;

    localparam int SIZE = 16;

`ifdef ROW_COL_DEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            err_clr = 1'b0;
    logic [15:0]     r_all = '0;
    logic [15:0]     row = '0;
    logic [15:0]     col = '0;
    logic [7:0]      word;
    logic            word_vld;
    logic            err;
    logic            err_sticky;
    logic [7:0]      err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         vld;
        bit         er;
        logic [7:0] w;
        bit         st;
        int         cnt;
    } exp_t;

    exp_t q[$];

    bit         pend_vld = 0;
    bit         pend_legal = 0;
    logic [7:0] pend_cand = '0;
    logic [7:0] m_word = 8'h80;
    bit         m_st = 0;
    int         m_cnt = 0;

    row_col_dec dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .r_all      (r_all),
        .row        (row),
        .col        (col),
        .err_clr    (err_clr),
        .word       (word),
        .word_vld   (word_vld),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int ones(logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic bit is_legal(logic [15:0] ra, logic [15:0] rw,
                                    logic [15:0] cl);
        int r = ones(ra);
        int c = ones(cl);
        int fill = (1 << c) - 1;
        if (!CHK) return 1'b1;
        if (r >= SIZE || c >= SIZE) return 1'b0;
        if (ra != 16'((1 << r) - 1)) return 1'b0;
        if (rw != 16'(1 << r)) return 1'b0;
        if (r % 2 == 0) return cl == 16'(fill);
        return cl == 16'(fill << (SIZE - c));
    endfunction

    function automatic logic [7:0] cand(logic [15:0] ra, logic [15:0] cl);
        return 8'(((ones(ra) % 16) << 4) | (ones(cl) % 16));
    endfunction

    function automatic void enc(input int w, output logic [15:0] ra,
                                output logic [15:0] rw, output logic [15:0] cl);
        int r = w / 16;
        int c = w % 16;
        ra = 16'((1 << r) - 1);
        rw = 16'(1 << r);
        cl = (r % 2 == 0) ? 16'((1 << c) - 1)
                          : 16'(((1 << c) - 1) << (SIZE - c));
    endfunction

    // Effect of the upcoming clock edge on the expected outputs.
    task automatic model_edge();
        exp_t e;
        if (pend_vld) begin
            if (pend_legal) m_word = pend_cand;
            if (err_clr) begin
                m_st  = 0;
                m_cnt = pend_legal ? 0 : 1;
            end else if (!pend_legal) begin
                m_st = 1;
                if (m_cnt < 255) m_cnt++;
            end
            e.vld = pend_legal;
            e.er  = !pend_legal;
            e.w   = m_word;
            e.st  = m_st;
            e.cnt = m_cnt;
            q.push_back(e);
        end else if (err_clr) begin
            m_st  = 0;
            m_cnt = 0;
        end
        pend_vld = en;
        if (en) begin
            pend_legal = is_legal(r_all, row, col);
            pend_cand  = cand(r_all, col);
        end
    endtask

    task automatic cycle(bit e, logic [15:0] ra, logic [15:0] rw,
                         logic [15:0] cl, bit clr);
        en      = e;
        r_all   = ra;
        row     = rw;
        col     = cl;
        err_clr = clr;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0);
    endtask

    task automatic peek(string tag);
        @(negedge clk);
        chk({tag, "_word"}, int'(word), int'(m_word));
        chk({tag, "_sticky"}, int'(err_sticky), int'(m_st));
        chk({tag, "_cnt"}, int'(err_cnt), m_cnt);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (word_vld || err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: word_vld=%0b err=%0b expected none",
                         word_vld, err);
            end else begin
                e = q.pop_front();
                chk("mon_vld", int'(word_vld), int'(e.vld));
                chk("mon_err", int'(err), int'(e.er));
                chk("mon_word", int'(word), int'(e.w));
                chk("mon_sticky", int'(err_sticky), int'(e.st));
                chk("mon_cnt", int'(err_cnt), e.cnt);
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rw;
        logic [15:0] cl;
        int k;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        @(negedge clk);
        chk("rst_word", int'(word), 8'h80);
        chk("rst_vld", int'(word_vld), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        cycle(1, 16'h0007, 16'h0008, 16'h001F, 0);
        idle(2);
        peek("r3_lsbcol");
        cycle(1, 16'h000F, 16'h0010, 16'h001F, 0);
        idle(2);
        peek("even_row");
        cycle(1, 16'h001F, 16'h0020, 16'hE000, 0);
        cycle(1, 16'h001F, 16'h0020, 16'h0007, 0);
        idle(2);
        peek("odd_row");

        cycle(1, 16'h0007, 16'h0010, 16'h0001, 0);
        idle(2);
        peek("mismatch");
        cycle(0, '0, '0, '0, 1);
        idle(1);
        peek("clear");

        cycle(1, 16'h0003, 16'h0004, 16'hFFFF, 0);
        cycle(0, '0, '0, '0, 1);
        idle(2);
        peek("clr_and_err");

        for (int w = 0; w < 256; w++) begin
            enc(w, ra, rw, cl);
            cycle(1, ra, rw, cl, 0);
        end
        idle(2);
        peek("stream");

        for (int i = 0; i < 300; i++) cycle(1, 16'hFFFF, 16'h0001, 16'h0000, 0);
        idle(2);
        peek("saturate");

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 2);
            enc($urandom_range(0, 255), ra, rw, cl);
            if (k == 0) begin
                ra = 16'($urandom);
                rw = 16'($urandom);
                cl = 16'($urandom);
            end else if (k == 1) begin
                case ($urandom_range(0, 2))
                    0: ra[$urandom_range(0, 15)] ^= 1'b1;
                    1: rw[$urandom_range(0, 15)] ^= 1'b1;
                    default: cl[$urandom_range(0, 15)] ^= 1'b1;
                endcase
            end
            cycle($urandom_range(0, 3) != 0, ra, rw, cl,
                  $urandom_range(0, 15) == 0);
        end
        idle(2);
        peek("random");

        enc(8'h3A, ra, rw, cl);
        cycle(1, ra, rw, cl, 0);
        en       = 1'b0;
        rst      = 1'b1;
        pend_vld = 0;
        m_word   = 8'h80;
        m_st     = 0;
        m_cnt    = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        peek("mid_reset");

        idle(2);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
